// File: rtl/enc_pkg.sv
// Shared types, register map and quadrature step decoder for the multi-channel encoder core.
package enc_pkg;

  typedef enum logic [1:0] {
    X4 = 2'b00,
    X2 = 2'b01,
    X1 = 2'b10
  } enc_mode_t;

  localparam logic [4:0] REG_STATUS   = 5'd0;
  localparam logic [4:0] REG_CTRL     = 5'd1;
  localparam logic [4:0] REG_CLEAR    = 5'd2;
  localparam logic [4:0] REG_CNT_BASE = 5'd8;

  // Returns {err, step}: step 2'b01 = +1, 2'b11 = -1, 2'b00 = no count. prev/curr are {A,B}.
  function automatic logic [2:0] qdec_step(input logic [1:0] prev, input logic [1:0] curr,
                                           input logic [1:0] mode);
    logic       fwd;
    logic [2:0] res;
    res = 3'b000;
    fwd = (prev == 2'b00 && curr == 2'b10) || (prev == 2'b10 && curr == 2'b11) ||
          (prev == 2'b11 && curr == 2'b01) || (prev == 2'b01 && curr == 2'b00);
    if ((prev ^ curr) == 2'b11) begin
      res = 3'b100;
    end else if (prev != curr) begin
      case (mode)
        X2: begin
          if (prev[1] != curr[1]) res = (curr[1] ^ curr[0]) ? 3'b001 : 3'b011;
        end
        X1: begin
          if (!prev[1] && curr[1]) res = curr[0] ? 3'b011 : 3'b001;
        end
        default: res = fwd ? 3'b001 : 3'b011;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/enc_chan.sv
// One encoder channel: pin synchronisers, glitch filters, quadrature decode and position counter.
module enc_chan
  import enc_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYC    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             b,
  input  logic             sw,
  input  logic [1:0]       mode,
  input  logic             sat,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sw_lvl,
  output logic             press_set,
  output logic             change_set,
  output logic             err_set
);

  localparam int unsigned      RunW    = $clog2(FILT_CYC + 1);
  localparam logic [RunW-1:0]  RunLast = RunW'(FILT_CYC - 1);
  localparam logic [CNT_W-1:0] CntMax  = {1'b0, {(CNT_W - 1){1'b1}}};
  localparam logic [CNT_W-1:0] CntMin  = {1'b1, {(CNT_W - 1){1'b0}}};

  // Pin bit order everywhere: [2]=A, [1]=B, [0]=SW.
  logic [2:0]       sync_q [SYNC_STAGES];
  logic [RunW-1:0]  run_q  [3];
  logic [2:0]       filt_q;
  logic [2:0]       synced;
  logic [1:0]       prev_q;
  logic             sw_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       dec;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int p = 0; p < 3; p++) run_q[p] <= '0;
      filt_q    <= '0;
      prev_q    <= '0;
      sw_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q[0] <= {a, b, sw};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      // A new level must differ for FILT_CYC consecutive cycles; any match restarts the run.
      for (int p = 0; p < 3; p++) begin
        if (synced[p] == filt_q[p]) begin
          run_q[p] <= '0;
        end else if (run_q[p] == RunLast) begin
          filt_q[p] <= synced[p];
          run_q[p]  <= '0;
        end else begin
          run_q[p] <= run_q[p] + RunW'(1);
        end
      end
      prev_q    <= filt_q[2:1];
      sw_prev_q <= filt_q[0];
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    dec   = qdec_step(prev_q, filt_q[2:1], mode);
    cnt_d = cnt_q;
    if (dec[1:0] == 2'b01) begin
      if (!(sat && cnt_q == CntMax)) cnt_d = cnt_q + CNT_W'(1);
    end else if (dec[1:0] == 2'b11) begin
      if (!(sat && cnt_q == CntMin)) cnt_d = cnt_q - CNT_W'(1);
    end
    if (clr) cnt_d = '0;
  end

  assign cnt        = cnt_q;
  assign sw_lvl     = filt_q[0];
  assign press_set  = filt_q[0] & ~sw_prev_q;
  assign change_set = (dec[1:0] != 2'b00);
  assign err_set    = dec[2];

endmodule

// File: rtl/chu_qenc_multi.sv
// Multi-channel quadrature encoder MMIO core: CTRL, sticky flags, read mux and level interrupt.
module chu_qenc_multi
  import enc_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYC    = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cs,
  input  logic            read,
  input  logic            write,
  input  logic [4:0]      addr,
  input  logic [31:0]     wr_data,
  output logic [31:0]     rd_data,
  input  logic [N_CH-1:0] enc_a,
  input  logic [N_CH-1:0] enc_b,
  input  logic [N_CH-1:0] enc_sw,
  output logic            irq
);

  logic [3:0]       ctrl_q;
  logic [N_CH-1:0]  press_q, change_q, err_q;
  logic [N_CH-1:0]  press_set, change_set, err_set, sw_lvl, clr;
  logic [CNT_W-1:0] cnt [N_CH];
  logic             wr_en, w1c;
  logic             unused_bus;

  assign wr_en      = cs & write;
  assign w1c        = wr_en && (addr == REG_STATUS);
  assign clr        = (wr_en && addr == REG_CLEAR) ? wr_data[N_CH-1:0] : '0;
  // Reads have no side effects, so the strobe is not needed.
  assign unused_bus = ^{read, wr_data};

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    enc_chan #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYC   (FILT_CYC)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .a         (enc_a[g]),
      .b         (enc_b[g]),
      .sw        (enc_sw[g]),
      .mode      (ctrl_q[1:0]),
      .sat       (ctrl_q[2]),
      .clr       (clr[g]),
      .cnt       (cnt[g]),
      .sw_lvl    (sw_lvl[g]),
      .press_set (press_set[g]),
      .change_set(change_set[g]),
      .err_set   (err_set[g])
    );
  end

  // Set pulses are OR-ed after the W1C mask so a coincident set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= '0;
      press_q  <= '0;
      change_q <= '0;
      err_q    <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en && addr == REG_CTRL) ctrl_q <= wr_data[3:0];
      press_q  <= (press_q  & ~(w1c ? wr_data[8 +: N_CH]  : '0)) | press_set;
      change_q <= (change_q & ~(w1c ? wr_data[16 +: N_CH] : '0)) | change_set;
      err_q    <= (err_q    & ~(w1c ? wr_data[24 +: N_CH] : '0)) | err_set;
      irq      <= ctrl_q[3] & |(press_q | change_q);
    end
  end

  always_comb begin
    rd_data = '0;
    if (addr == REG_STATUS) begin
      rd_data[0 +: N_CH]  = sw_lvl;
      rd_data[8 +: N_CH]  = press_q;
      rd_data[16 +: N_CH] = change_q;
      rd_data[24 +: N_CH] = err_q;
    end else if (addr == REG_CTRL) begin
      rd_data[3:0] = ctrl_q;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (addr == REG_CNT_BASE + 5'(i)) rd_data = 32'($signed(cnt[i]));
    end
  end

endmodule

// File: tb/tb_chu_qenc_multi.sv
// Directed bench for chu_qenc_multi: decode table plus hand-timed latency/collision/irq/reset cases.
module tb_chu_qenc_multi;

  logic        clk = 1'b0;
  logic        reset_n, cs, cs4, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data, rd_data4;
  logic [1:0]  enc_a, enc_b, enc_sw;
  logic [0:0]  a4, b4, sw4;
  logic        irq, irq4;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [1:0] mode;
    bit         clr;
    bit         w1c;
    logic [1:0] ab;
    int         exp_cnt;
    bit         exp_err;
  } vec_t;

  vec_t vecs [15];

  always #5 clk = ~clk;

  chu_qenc_multi #(.N_CH(2), .CNT_W(16), .SYNC_STAGES(2), .FILT_CYC(4)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .read(read), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw),
    .irq(irq)
  );

  chu_qenc_multi #(.N_CH(1), .CNT_W(4), .SYNC_STAGES(2), .FILT_CYC(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .cs(cs4), .read(read), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data4), .enc_a(a4), .enc_b(b4), .enc_sw(sw4),
    .irq(irq4)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic reg_write(input bit sel, input logic [4:0] a, input logic [31:0] d);
    if (sel) cs4 = 1'b1;
    else cs = 1'b1;
    write   = 1'b1;
    addr    = a;
    wr_data = d;
    @(negedge clk);
    cs      = 1'b0;
    cs4     = 1'b0;
    write   = 1'b0;
    wr_data = '0;
  endtask

  task automatic reg_read(input bit sel, input logic [4:0] a, output logic [31:0] d);
    addr = a;
    read = 1'b1;
    #1;
    d    = sel ? rd_data4 : rd_data;
    read = 1'b0;
  endtask

  task automatic set_ab(input bit sel, input logic [1:0] ab);
    if (sel) begin
      a4[0] = ab[1];
      b4[0] = ab[0];
    end else begin
      enc_a[0] = ab[1];
      enc_b[0] = ab[0];
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  cw [4];
    cw = '{2'b10, 2'b11, 2'b01, 2'b00};

    // {mode, clr, w1c_err, ab, expected cnt0, expected err0}; starts at cnt0=4, ab=00.
    vecs[0]  = '{2'd1, 1'b1, 1'b0, 2'b01,  0, 1'b0};
    vecs[1]  = '{2'd1, 1'b0, 1'b0, 2'b11, -1, 1'b0};
    vecs[2]  = '{2'd1, 1'b0, 1'b0, 2'b10, -1, 1'b0};
    vecs[3]  = '{2'd1, 1'b0, 1'b0, 2'b00, -2, 1'b0};
    vecs[4]  = '{2'd2, 1'b1, 1'b0, 2'b01,  0, 1'b0};
    vecs[5]  = '{2'd2, 1'b0, 1'b0, 2'b11, -1, 1'b0};
    vecs[6]  = '{2'd2, 1'b0, 1'b0, 2'b10, -1, 1'b0};
    vecs[7]  = '{2'd2, 1'b0, 1'b0, 2'b00, -1, 1'b0};
    vecs[8]  = '{2'd2, 1'b0, 1'b0, 2'b10,  0, 1'b0};
    vecs[9]  = '{2'd3, 1'b0, 1'b0, 2'b11,  1, 1'b0};
    vecs[10] = '{2'd0, 1'b0, 1'b0, 2'b00,  1, 1'b1};
    vecs[11] = '{2'd0, 1'b0, 1'b0, 2'b01,  0, 1'b1};
    vecs[12] = '{2'd0, 1'b0, 1'b1, 2'b11, -1, 1'b0};
    vecs[13] = '{2'd0, 1'b0, 1'b0, 2'b10, -2, 1'b0};
    vecs[14] = '{2'd2, 1'b0, 1'b0, 2'b01, -2, 1'b1};

    reset_n = 1'b0; cs = 1'b0; cs4 = 1'b0; read = 1'b0; write = 1'b0;
    addr = '0; wr_data = '0; enc_a = '0; enc_b = '0; enc_sw = '0;
    a4 = '0; b4 = '0; sw4 = '0;
    tick(3);
    reset_n = 1'b1;
    tick(2);

    reg_read(0, 5'd0, d); check("rst_status", d, 32'h0);
    reg_read(0, 5'd1, d); check("rst_ctrl", d, 32'h0);
    reg_read(0, 5'd8, d); check("rst_cnt0", d, 32'h0);
    reg_read(0, 5'd9, d); check("rst_cnt1", d, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);

    // x4 clockwise with exact first-edge latency
    set_ab(0, 2'b10);
    tick(6);
    reg_read(0, 5'd8, d); check("lat_6clk", d, 32'h0);
    tick(1);
    reg_read(0, 5'd8, d); check("lat_7clk", d, 32'h1);
    set_ab(0, 2'b11); tick(4);
    set_ab(0, 2'b01); tick(4);
    set_ab(0, 2'b00); tick(8);
    reg_read(0, 5'd8, d); check("cw_x4_cnt", d, 32'd4);
    reg_read(0, 5'd0, d); check("cw_x4_status", d, 32'h0001_0000);

    for (int i = 0; i < 15; i++) begin
      reg_write(0, 5'd1, {30'd0, vecs[i].mode});
      if (vecs[i].clr) reg_write(0, 5'd2, 32'h1);
      if (vecs[i].w1c) reg_write(0, 5'd0, 32'hFF00_0000);
      set_ab(0, vecs[i].ab);
      tick(8);
      reg_read(0, 5'd8, d); check($sformatf("vec%0d_cnt", i), d, 32'(vecs[i].exp_cnt));
      reg_read(0, 5'd0, d); check($sformatf("vec%0d_err", i), {31'd0, d[24]}, {31'd0, vecs[i].exp_err});
    end

    // 3-cycle glitch on A must not count (ab is 01 here)
    reg_write(0, 5'd1, 32'h0);
    reg_write(0, 5'd2, 32'h1);
    set_ab(0, 2'b11); tick(3);
    set_ab(0, 2'b01); tick(10);
    reg_read(0, 5'd8, d); check("glitch_cnt", d, 32'h0);

    // W1C of err landing in the same cycle as a new illegal jump
    reg_write(0, 5'd0, 32'hFFFF_FF00);
    set_ab(0, 2'b10);
    tick(6);
    reg_write(0, 5'd0, 32'hFF00_0000);
    reg_read(0, 5'd0, d); check("w1c_vs_err", {31'd0, d[24]}, 32'h1);
    reg_read(0, 5'd8, d); check("jump_cnt", d, 32'h0);
    reg_write(0, 5'd0, 32'hFF00_0000);
    reg_read(0, 5'd0, d); check("err_cleared", {31'd0, d[24]}, 32'h0);

    // CLEAR coincident with a count step
    set_ab(0, 2'b11); tick(8);
    reg_read(0, 5'd8, d); check("pre_clr_cnt", d, 32'h1);
    reg_write(0, 5'd0, 32'h00FF_0000);
    set_ab(0, 2'b01);
    tick(6);
    reg_write(0, 5'd2, 32'h1);
    reg_read(0, 5'd8, d); check("clr_vs_step_cnt", d, 32'h0);
    reg_read(0, 5'd0, d); check("clr_vs_step_change", {31'd0, d[16]}, 32'h1);

    // press on ch1 with irq enabled
    reg_write(0, 5'd0, 32'hFFFF_FF00);
    reg_write(0, 5'd1, 32'h8);
    check("irq_idle", {31'd0, irq}, 32'h0);
    enc_sw[1] = 1'b1;
    tick(7);
    reg_read(0, 5'd0, d); check("press_status", d, 32'h0000_0202);
    check("irq_not_yet", {31'd0, irq}, 32'h0);
    tick(1);
    check("irq_set", {31'd0, irq}, 32'h1);
    reg_write(0, 5'd0, 32'h0000_0200);
    check("irq_lag", {31'd0, irq}, 32'h1);
    tick(1);
    check("irq_cleared", {31'd0, irq}, 32'h0);
    reg_read(0, 5'd0, d); check("press_cleared", d, 32'h0000_0002);
    reg_read(0, 5'd20, d); check("unmapped_read", d, 32'h0);

    // reset mid-rotation
    set_ab(0, 2'b11);
    tick(3);
    reset_n = 1'b0;
    #1;
    reg_read(0, 5'd0, d); check("mid_rst_status", d, 32'h0);
    reg_read(0, 5'd1, d); check("mid_rst_ctrl", d, 32'h0);
    reg_read(0, 5'd8, d); check("mid_rst_cnt0", d, 32'h0);
    check("mid_rst_known", {31'd0, $isunknown(d)}, 32'h0);
    check("mid_rst_irq", {31'd0, irq}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // 4-bit counter: saturate then wrap
    reg_write(1, 5'd1, 32'h4);
    for (int k = 0; k < 10; k++) begin
      set_ab(1, cw[k % 4]);
      tick(6);
    end
    tick(4);
    reg_read(1, 5'd8, d); check("sat_cnt", d, 32'h0000_0007);
    reg_write(1, 5'd0, 32'hFFFF_FF00);
    set_ab(1, cw[10 % 4]);
    tick(10);
    reg_read(1, 5'd8, d); check("sat_hold_cnt", d, 32'h0000_0007);
    reg_read(1, 5'd0, d); check("sat_rail_change", d, 32'h0001_0000);
    reg_read(1, 5'd9, d); check("ch_oob_read", d, 32'h0);
    reg_write(1, 5'd1, 32'h0);
    reg_write(1, 5'd2, 32'h1);
    for (int k = 11; k < 19; k++) begin
      set_ab(1, cw[k % 4]);
      tick(6);
    end
    tick(4);
    reg_read(1, 5'd8, d); check("wrap_cnt", d, 32'hFFFF_FFF8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
